// File: rtl/berexp_sched_pkg.sv
// rtl/berexp_sched_pkg.sv - shared types and default sizing for the BerExp scheduler
package berexp_sched_pkg;

    typedef enum logic {
        S_DRAIN = 1'b0,
        S_RUN   = 1'b1
    } sched_state_e;

    localparam int DEF_FIFO_DEPTH   = 8;
    localparam int DEF_DRAIN_CYCLES = 40;

endpackage

// File: rtl/berexp_sfifo.sv
// rtl/berexp_sfifo.sv - small synchronous FIFO with registered storage and head output
module berexp_sfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_wr, do_rd;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_wr   = wr_en_i && !full_o;
    assign do_rd   = rd_en_i && !empty_o;
    // Head reads as zero when empty so stale entries never leak after a reset.
    assign head_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_wr) begin
            mem_d[wptr_q[AW-1:0]] = wr_data_i;
            wptr_d                = wptr_q + 1'b1;
        end
        if (do_rd) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/berexp_sched.sv
// rtl/berexp_sched.sv - round-robin sharing of one fixed-latency BerExp pipeline between sampler lanes
module berexp_sched
    import berexp_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = $clog2(NUM_REQ),
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_val_i,
    output logic [NUM_REQ-1:0]    req_rdy_o,
    input  logic [64*NUM_REQ-1:0] req_ccs_i,
    input  logic [64*NUM_REQ-1:0] req_x_i,
    input  logic [8*NUM_REQ-1:0]  req_rand_i,
    output logic                  be_din_val_o,
    output logic [63:0]           be_ccs_o,
    output logic [63:0]           be_x_o,
    output logic [7:0]            be_rand_8_o,
    input  logic                  be_dout_val_i,
    input  logic                  be_w_i,
    output logic                  res_val_o,
    input  logic                  res_rdy_i,
    output logic [ID_W-1:0]       res_id_o,
    output logic                  res_w_o,
    output logic                  err_o
);
    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam int CR_W  = $clog2(FIFO_DEPTH + 1);

    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [CR_W-1:0]  credit_q, credit_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic             be_din_val_q, be_din_val_d;
    logic [63:0]      be_ccs_q, be_ccs_d;
    logic [63:0]      be_x_q, be_x_d;
    logic [7:0]       be_rand_q, be_rand_d;
    logic             err_q, err_d;

    logic             run, grant, pop, be_accept;
    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic [63:0]      win_ccs, win_x;
    logic [7:0]       win_rand;
    logic [ID_W-1:0]  tag_head;
    logic [ID_W:0]    res_head;
    logic             tag_empty, res_empty;
    logic             tag_full_unused, res_full_unused;

    assign run       = (state_q == S_RUN);
    assign grant     = run && (credit_q != '0) && win_found;
    assign pop       = res_val_o && res_rdy_i;
    assign be_accept = be_dout_val_i && run && !tag_empty;

    // Pass 0 scans lanes above the last winner, pass 1 wraps to lanes at or below it.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_ccs   = '0;
        win_x     = '0;
        win_rand  = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!win_found && req_val_i[i] && ((p == 0) == (i > int'(last_q)))) begin
                    win_found = 1'b1;
                    win_id    = ID_W'(i);
                    win_ccs   = req_ccs_i[64*i +: 64];
                    win_x     = req_x_i[64*i +: 64];
                    win_rand  = req_rand_i[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        req_rdy_o = '0;
        if (grant) begin
            req_rdy_o[win_id] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        credit_d     = credit_q;
        last_d       = last_q;
        be_din_val_d = grant;
        be_ccs_d     = be_ccs_q;
        be_x_d       = be_x_q;
        be_rand_d    = be_rand_q;
        err_d        = err_q | (be_dout_val_i && run && tag_empty);
        if (state_q == S_DRAIN) begin
            if (drain_cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                state_d = S_RUN;
            end else begin
                drain_cnt_d = drain_cnt_q + 1'b1;
            end
        end
        case ({grant, pop})
            2'b10:   credit_d = credit_q - 1'b1;
            2'b01:   credit_d = credit_q + 1'b1;
            default: credit_d = credit_q;
        endcase
        if (grant) begin
            last_d    = win_id;
            be_ccs_d  = win_ccs;
            be_x_d    = win_x;
            be_rand_d = win_rand;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_DRAIN;
            drain_cnt_q  <= '0;
            credit_q     <= CR_W'(FIFO_DEPTH);
            last_q       <= ID_W'(NUM_REQ - 1);
            be_din_val_q <= 1'b0;
            be_ccs_q     <= '0;
            be_x_q       <= '0;
            be_rand_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            credit_q     <= credit_d;
            last_q       <= last_d;
            be_din_val_q <= be_din_val_d;
            be_ccs_q     <= be_ccs_d;
            be_x_q       <= be_x_d;
            be_rand_q    <= be_rand_d;
            err_q        <= err_d;
        end
    end

    berexp_sfifo #(.WIDTH(ID_W), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (grant),
        .wr_data_i (win_id),
        .rd_en_i   (be_accept),
        .head_o    (tag_head),
        .full_o    (tag_full_unused),
        .empty_o   (tag_empty)
    );

    berexp_sfifo #(.WIDTH(ID_W + 1), .DEPTH(FIFO_DEPTH)) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (be_accept),
        .wr_data_i ({tag_head, be_w_i}),
        .rd_en_i   (res_rdy_i),
        .head_o    (res_head),
        .full_o    (res_full_unused),
        .empty_o   (res_empty)
    );

    assign be_din_val_o = be_din_val_q;
    assign be_ccs_o     = be_ccs_q;
    assign be_x_o       = be_x_q;
    assign be_rand_8_o  = be_rand_q;
    assign res_val_o    = !res_empty;
    assign res_id_o     = res_head[ID_W:1];
    assign res_w_o      = res_head[0];
    assign err_o        = err_q;

endmodule

// File: tb/tb_berexp_sched.sv
// tb/tb_berexp_sched.sv - directed bench for berexp_sched with a 40-cycle BerExp delay model
module tb_berexp_sched;
    localparam int LAT = 40;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     req_val_i;
    logic [3:0]     req_rdy_o;
    logic [255:0]   req_ccs_i, req_x_i;
    logic [31:0]    req_rand_i;
    logic           be_din_val_o;
    logic [63:0]    be_ccs_o, be_x_o;
    logic [7:0]     be_rand_8_o;
    logic           be_dout_val_i, be_w_i;
    logic           res_val_o, res_rdy_i;
    logic [1:0]     res_id_o;
    logic           res_w_o, err_o;
    logic           inj_v = 1'b0;
    logic [LAT-1:0] pipe_v = '0;
    logic [LAT-1:0] pipe_w = '0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [1:0] exp_q[$];

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic [3:0] exp_rdy;
    } vec_t;
    vec_t tab[$];

    always #5 clk = ~clk;

    berexp_sched #(.NUM_REQ(4), .FIFO_DEPTH(8), .DRAIN_CYCLES(40)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_val_i     (req_val_i),
        .req_rdy_o     (req_rdy_o),
        .req_ccs_i     (req_ccs_i),
        .req_x_i       (req_x_i),
        .req_rand_i    (req_rand_i),
        .be_din_val_o  (be_din_val_o),
        .be_ccs_o      (be_ccs_o),
        .be_x_o        (be_x_o),
        .be_rand_8_o   (be_rand_8_o),
        .be_dout_val_i (be_dout_val_i),
        .be_w_i        (be_w_i),
        .res_val_o     (res_val_o),
        .res_rdy_i     (res_rdy_i),
        .res_id_o      (res_id_o),
        .res_w_o       (res_w_o),
        .err_o         (err_o)
    );

    // BerExp stand-in: valid pipe is never reset, result bit is x[0].
    always @(posedge clk) begin
        pipe_v <= {pipe_v[LAT-2:0], be_din_val_o};
        pipe_w <= {pipe_w[LAT-2:0], be_x_o[0]};
    end
    assign be_dout_val_i = pipe_v[LAT-1] | inj_v;
    assign be_w_i        = pipe_w[LAT-1];

    function automatic logic [63:0] lane_x(input logic [1:0] id);
        case (id)
            2'd0:    return 64'h4000_0000_0000_0000;
            2'd1:    return 64'h4000_0000_0000_0011;
            2'd2:    return 64'h4000_0000_0000_0021;
            default: return 64'h4000_0000_0000_0030;
        endcase
    endfunction

    function automatic logic [63:0] lane_ccs(input logic [1:0] id);
        return {56'hC0DE_0000_0000_00, 6'd0, id};
    endfunction

    function automatic logic [7:0] lane_rand(input logic [1:0] id);
        return {6'b101001, id};
    endfunction

    function automatic logic exp_w(input logic [1:0] id);
        return (id == 2'd1) || (id == 2'd2);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic add(input logic [3:0] req, input logic rdy, input logic [3:0] exp_rdy);
        vec_t v;
        v.req = req;
        v.rdy = rdy;
        v.exp_rdy = exp_rdy;
        tab.push_back(v);
    endtask

    task automatic run_tab(input string name);
        foreach (tab[k]) begin
            step();
            req_val_i = tab[k].req;
            res_rdy_i = tab[k].rdy;
            #1;
            chk(name, req_rdy_o, tab[k].exp_rdy);
        end
        tab.delete();
    endtask

    task automatic collect(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            req_val_i = '0;
            res_rdy_i = 1'b1;
            #1;
            n++;
            if (res_val_o) begin
                chk("res_id", res_id_o, exp_q[0]);
                chk("res_w", res_w_o, exp_w(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
        if (exp_q.size() != 0) begin
            chk("res_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        step();
        #1;
        chk("res_extra", res_val_o, 1'b0);
    endtask

    task automatic check_reset_values();
        chk("rst_req_rdy", req_rdy_o, 4'h0);
        chk("rst_din_val", be_din_val_o, 1'b0);
        chk("rst_ccs", be_ccs_o, 64'h0);
        chk("rst_x", be_x_o, 64'h0);
        chk("rst_rand", be_rand_8_o, 8'h0);
        chk("rst_res_val", res_val_o, 1'b0);
        chk("rst_res_id", res_id_o, 2'd0);
        chk("rst_res_w", res_w_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        req_val_i  = '0;
        res_rdy_i  = 1'b1;
        req_ccs_i  = {lane_ccs(2'd3), lane_ccs(2'd2), lane_ccs(2'd1), lane_ccs(2'd0)};
        req_x_i    = {lane_x(2'd3), lane_x(2'd2), lane_x(2'd1), lane_x(2'd0)};
        req_rand_i = {lane_rand(2'd3), lane_rand(2'd2), lane_rand(2'd1), lane_rand(2'd0)};
        repeat (3) @(negedge clk);
        #1;
        check_reset_values();

        // Drain window: lane 0 held valid, first grant in cycle 40.
        rst = 1'b0;
        cyc = 0;
        req_val_i = 4'h1;
        #1;
        for (int c = 0; c <= 40; c++) begin
            if (c != 0) begin
                step();
                #1;
            end
            chk("drain_rdy", req_rdy_o, (c == 40) ? 4'h1 : 4'h0);
            chk("drain_din", be_din_val_o, 1'b0);
        end
        step();
        req_val_i = '0;
        #1;
        chk("issue_din", be_din_val_o, 1'b1);
        chk("issue_ccs", be_ccs_o, lane_ccs(2'd0));
        chk("issue_x", be_x_o, lane_x(2'd0));
        chk("issue_rand", be_rand_8_o, lane_rand(2'd0));
        chk("issue_rdy", req_rdy_o, 4'h0);
        step();
        #1;
        chk("issue_din_off", be_din_val_o, 1'b0);
        while (cyc < 81) begin
            step();
            #1;
        end
        chk("first_res_early", res_val_o, 1'b0);
        step();
        #1;
        chk("first_res_val", res_val_o, 1'b1);
        chk("first_res_id", res_id_o, 2'd0);
        chk("first_res_w", res_w_o, 1'b0);
        step();
        #1;
        chk("first_res_popped", res_val_o, 1'b0);

        // Round robin over all lanes until the 8 credits are spent.
        add(4'hF, 1'b1, 4'h2); add(4'hF, 1'b1, 4'h4); add(4'hF, 1'b1, 4'h8);
        add(4'hF, 1'b1, 4'h1); add(4'hF, 1'b1, 4'h2); add(4'hF, 1'b1, 4'h4);
        add(4'hF, 1'b1, 4'h8); add(4'hF, 1'b1, 4'h1); add(4'hF, 1'b1, 4'h0);
        run_tab("rr_grant");
        exp_q = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        collect(70);

        // Backpressure: results pile up, then a single pop frees a single grant.
        add(4'hF, 1'b0, 4'h2); add(4'hF, 1'b0, 4'h4); add(4'hF, 1'b0, 4'h8);
        add(4'hF, 1'b0, 4'h1); add(4'hF, 1'b0, 4'h2); add(4'hF, 1'b0, 4'h4);
        add(4'hF, 1'b0, 4'h8); add(4'hF, 1'b0, 4'h1); add(4'hF, 1'b0, 4'h0);
        add(4'hF, 1'b0, 4'h0);
        run_tab("bp_grant");
        repeat (45) begin
            step();
            req_val_i = 4'hF;
            res_rdy_i = 1'b0;
            #1;
            chk("bp_stall", req_rdy_o, 4'h0);
        end
        chk("bp_hold_val", res_val_o, 1'b1);
        chk("bp_hold_id", res_id_o, 2'd1);
        chk("bp_hold_w", res_w_o, exp_w(2'd1));
        step();
        res_rdy_i = 1'b1;
        #1;
        chk("bp_pop_cycle", req_rdy_o, 4'h0);
        step();
        res_rdy_i = 1'b0;
        #1;
        chk("bp_regrant", req_rdy_o, 4'h2);
        chk("bp_next_id", res_id_o, 2'd2);
        step();
        #1;
        chk("bp_single", req_rdy_o, 4'h0);
        exp_q = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        collect(80);

        // Only lanes 1 and 3 requesting.
        add(4'hA, 1'b1, 4'h8); add(4'hA, 1'b1, 4'h2);
        add(4'hA, 1'b1, 4'h8); add(4'hA, 1'b1, 4'h2);
        run_tab("sparse_grant");
        exp_q = '{2'd3, 2'd1, 2'd3, 2'd1};
        collect(60);

        // Unexpected BerExp result with nothing in flight.
        step();
        inj_v = 1'b1;
        #1;
        chk("err_before", err_o, 1'b0);
        step();
        inj_v = 1'b0;
        #1;
        chk("err_set", err_o, 1'b1);
        chk("err_no_res", res_val_o, 1'b0);
        repeat (3) begin
            step();
            #1;
            chk("err_sticky", err_o, 1'b1);
            chk("err_no_res", res_val_o, 1'b0);
        end

        // Reset with five requests in the BerExp pipe.
        add(4'hF, 1'b1, 4'h4); add(4'hF, 1'b1, 4'h8); add(4'hF, 1'b1, 4'h1);
        add(4'hF, 1'b1, 4'h2); add(4'hF, 1'b1, 4'h4);
        run_tab("pre_rst_grant");
        step();
        req_val_i = '0;
        #1;
        chk("pre_rst_din", be_din_val_o, 1'b1);
        step();
        rst = 1'b1;
        #1;
        check_reset_values();
        step();
        rst = 1'b0;
        cyc = 0;
        #1;
        repeat (45) begin
            step();
            #1;
            chk("flush_res_val", res_val_o, 1'b0);
            chk("flush_err", err_o, 1'b0);
            chk("flush_rdy", req_rdy_o, 4'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
